// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and sizes for the register-file port-1 arbiter.
// Grant encoding is shared by the arbiter core and anything observing it.
package anna_regfile_pkg;

  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_A,
    GNT_B
  } grant_t;

  function automatic logic is_write_grant(grant_t g);
    return (g == GNT_A) || (g == GNT_B);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Bundle of requester handshakes and register-file port-1 controls.
// master = requesters plus register-file sink, slave = the arbiter.
interface regfile_port_arbiter_if
  import anna_regfile_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // Handshake: a transfer happens in the cycle valid && ready; the requester
  // holds valid and its payload stable until it sees ready, and ready is a
  // same-cycle function of the current grant (no dependence on a later cycle).
  logic                 rd_valid;
  logic                 rd_ready;
  logic [REG_IDX_W-1:0] rd_addr;

  logic                 a_valid;
  logic                 a_ready;
  logic [REG_IDX_W-1:0] a_rd;
  logic [DATA_W-1:0]    a_data;

  logic                 b_valid;
  logic                 b_ready;
  logic [REG_IDX_W-1:0] b_rd;
  logic [DATA_W-1:0]    b_data;

  logic                 r_en1;
  logic                 w_en;
  logic [ADDR_W-1:0]    reg1;
  logic [DATA_W-1:0]    w_data;
  logic                 rd_issued;

  modport master (
    output rd_valid, rd_addr, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  rd_ready, a_ready, b_ready, r_en1, w_en, reg1, w_data, rd_issued
  );

  modport slave (
    input  rd_valid, rd_addr, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output rd_ready, a_ready, b_ready, r_en1, w_en, reg1, w_data, rd_issued
  );

endinterface

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-way round-robin selector; last_b_q remembers whether B won last.
// A lone requester always wins; on a tie the side that did not win last wins.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic adv_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_b_q;

  assign gnt_a_o = req_a_i && (!req_b_i || last_b_q);
  assign gnt_b_o = req_b_i && !gnt_a_o;

  // Reset to "B won last" so A takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else if (adv_i) begin
      last_b_q <= gnt_b_o;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates register-file port 1 between decode reads and two writebacks.
// Optional: define ARB_DROP_R0_EN to swallow writes to r0 without a port cycle.
module regfile_port_arbiter
  import anna_regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16
) (
  input logic                 clk,
  input logic                 reset,
  regfile_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  grant_t               grant;
  logic                 wr_any;
  logic                 wr_grant;
  logic                 arb_a;
  logic                 arb_b;
  logic                 drop_wr;
  logic [REG_IDX_W-1:0] wr_rd;
  logic [DATA_W-1:0]    wr_data;

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              r_en1_q, w_en_q, rd_issued_q;
  logic [ADDR_W-1:0] reg1_q;
  logic [DATA_W-1:0] w_data_q;

  assign wr_any = bus.a_valid | bus.b_valid;

  rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req_a_i (bus.a_valid),
    .req_b_i (bus.b_valid),
    .adv_i   (wr_grant),
    .gnt_a_o (arb_a),
    .gnt_b_o (arb_b)
  );

  // A starved write jumps ahead of reads; otherwise reads beat writes.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (wr_any && (starve_q == LIMIT_C || !bus.rd_valid)) begin
        grant = arb_a ? GNT_A : (arb_b ? GNT_B : GNT_NONE);
      end else if (bus.rd_valid) begin
        grant = GNT_RD;
      end
    end
  end

  assign wr_grant = is_write_grant(grant);
  assign wr_rd    = (grant == GNT_A) ? bus.a_rd   : bus.b_rd;
  assign wr_data  = (grant == GNT_A) ? bus.a_data : bus.b_data;

`ifdef ARB_DROP_R0_EN
  assign drop_wr = (wr_rd == '0);
`else
  assign drop_wr = 1'b0;
`endif

  always_comb begin
    starve_d = starve_q;
    if (wr_grant || !wr_any) begin
      starve_d = '0;
    end else if (grant == GNT_RD && starve_q != LIMIT_C) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q    <= '0;
      r_en1_q     <= 1'b0;
      w_en_q      <= 1'b0;
      rd_issued_q <= 1'b0;
      reg1_q      <= '0;
      w_data_q    <= '0;
    end else begin
      starve_q    <= starve_d;
      r_en1_q     <= (grant == GNT_RD);
      rd_issued_q <= (grant == GNT_RD);
      w_en_q      <= wr_grant && !drop_wr;
      if (grant == GNT_RD) begin
        reg1_q <= ADDR_W'(bus.rd_addr);
      end else if (wr_grant && !drop_wr) begin
        reg1_q   <= ADDR_W'(wr_rd);
        w_data_q <= wr_data;
      end
    end
  end

  assign bus.rd_ready = (grant == GNT_RD);
  assign bus.a_ready  = (grant == GNT_A);
  assign bus.b_ready  = (grant == GNT_B);

  // Enables are masked by reset so a transfer registered just before reset
  // never reaches the register file.
  assign bus.r_en1     = r_en1_q & ~reset;
  assign bus.w_en      = w_en_q & ~reset;
  assign bus.rd_issued = rd_issued_q & ~reset;
  assign bus.reg1      = reg1_q;
  assign bus.w_data    = w_data_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter with a spec-level model and
// a behavioural register file fed from the DUT's port-1 controls.
module tb_regfile_port_arbiter;
  import anna_regfile_pkg::*;

  localparam int LIMIT = 4;
  localparam int OW    = 35; // {r_en1, w_en, rd_issued, reg1[15:0], w_data[15:0]}

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_port_arbiter_if bus ();

  regfile_port_arbiter #(
    .STARVE_LIMIT (LIMIT),
    .ADDR_W       (16),
    .DATA_W       (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // requester-side stimulus state
  logic        rst;
  logic        rv, av, bv;
  logic [2:0]  ra, ard, brd;
  logic [15:0] ad, bd;

  // reference model state
  int             m_starve;
  bit             m_last_b;
  logic           m_ren, m_wen, m_iss;
  logic [15:0]    m_reg1, m_wdata;
  logic [OW-1:0]  exp_q[$];
  logic [15:0]    exp_rf[8];
  logic [15:0]    act_rf[8];

  initial for (int i = 0; i < 8; i++) act_rf[i] = 16'h0;

  // register_file stand-in: r0 is hardwired to zero
  always @(posedge clk) begin
    if (bus.w_en && bus.reg1[2:0] != 3'd0) act_rf[bus.reg1[2:0]] <= bus.w_data;
  end

  always @(negedge clk) begin
    checks++;
    if (bus.w_en && bus.r_en1) begin
      errors++;
      $display("FAIL port_conflict t=%0t w_en=%b r_en1=%b required not both 1", $time, bus.w_en, bus.r_en1);
    end
  end

  task automatic model_reset();
    m_starve = 0; m_last_b = 1'b1;
    m_ren = 1'b0; m_wen = 1'b0; m_iss = 1'b0;
    m_reg1 = 16'h0; m_wdata = 16'h0;
  endtask

  // Drives one cycle: applies stimulus, samples, advances the model.
  task automatic run_cycle(output logic [2:0] exp_rdy, output logic [2:0] act_rdy,
                           output logic [OW-1:0] exp_o, output logic [OW-1:0] act_o);
    grant_t        g;
    logic [OW-1:0] w;
    logic [2:0]    idx, dst;
    logic [15:0]   dat;
    bit            wr_any, drop;
    reset = rst;
    bus.rd_valid = rv; bus.rd_addr = ra;
    bus.a_valid = av; bus.a_rd = ard; bus.a_data = ad;
    bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bd;
    #1;
    w = (exp_q.size() != 0) ? exp_q.pop_front() : {OW{1'b1}};
    if (rst) w[OW-1 -: 3] = 3'b000;
    idx = w[18:16];
    if (w[33] && idx != 3'd0) exp_rf[idx] = w[15:0];
    exp_o = w;
    act_o = {bus.r_en1, bus.w_en, bus.rd_issued, bus.reg1, bus.w_data};
    g = GNT_NONE;
    wr_any = av || bv;
    if (!rst) begin
      if (wr_any && (m_starve == LIMIT || !rv)) g = (av && (!bv || m_last_b)) ? GNT_A : GNT_B;
      else if (rv) g = GNT_RD;
    end
    exp_rdy = {g == GNT_RD, g == GNT_A, g == GNT_B};
    act_rdy = {bus.rd_ready, bus.a_ready, bus.b_ready};
    if (rst) begin
      model_reset();
    end else begin
      m_ren = (g == GNT_RD); m_iss = m_ren; m_wen = 1'b0;
      if (g == GNT_RD) m_reg1 = {13'h0, ra};
      if (g == GNT_A || g == GNT_B) begin
        m_last_b = (g == GNT_B);
        dst = (g == GNT_A) ? ard : brd;
        dat = (g == GNT_A) ? ad : bd;
`ifdef ARB_DROP_R0_EN
        drop = (dst == 3'd0);
`else
        drop = 1'b0;
`endif
        if (!drop) begin m_wen = 1'b1; m_reg1 = {13'h0, dst}; m_wdata = dat; end
        m_starve = 0;
      end else if (!wr_any) begin
        m_starve = 0;
      end else if (g == GNT_RD && m_starve < LIMIT) begin
        m_starve = m_starve + 1;
      end
    end
    exp_q.push_back({m_ren, m_wen, m_iss, m_reg1, m_wdata});
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    rv = 1'b0; av = 1'b0; bv = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] er, ar; logic [OW-1:0] eo, ao;
    rst = 1'b1; rv = 1'b1; av = 1'b1; bv = 1'b1; ra = 3'd5; ard = 3'd6; brd = 3'd7;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin rst = 1'b0; idle_inputs(); end
      run_cycle(er, ar, eo, ao);
      checks += 2;
      if (ar !== 3'b000) begin errors++; $display("FAIL reset_ready cyc=%0d act=%b req=000", i, ar); end
      if (ao !== {OW{1'b0}}) begin errors++; $display("FAIL reset_out cyc=%0d act=%h req=0 model=%h", i, ao, eo); end
    end
  endtask

  task automatic test_single_write();
    logic [2:0] er, ar; logic [OW-1:0] eo, ao;
    av = 1'b1; ard = 3'd1; ad = 16'h0102;
    for (int i = 0; i < 3; i++) begin
      run_cycle(er, ar, eo, ao);
      checks += 2;
      if (ar !== er || (i == 0 && ar !== 3'b010)) begin errors++; $display("FAIL single_write_ready cyc=%0d act=%b req=%b", i, ar, er); end
      if (ao !== eo || (i == 1 && ao !== {3'b010, 16'h0001, 16'h0102})) begin errors++; $display("FAIL single_write_out cyc=%0d act=%h req=%h", i, ao, eo); end
      av = 1'b0;
    end
    checks++;
    if (act_rf[1] !== 16'h0102) begin errors++; $display("FAIL single_write_rf r1=%h req=0102", act_rf[1]); end
  endtask

  task automatic test_read_vs_write();
    logic [2:0] er, ar; logic [OW-1:0] eo, ao;
    logic [2:0] want_r[3]; logic [OW-1:0] want_o[3];
    want_r[0] = 3'b100; want_r[1] = 3'b010; want_r[2] = 3'b000;
    want_o[0] = {3'b000, 16'h0001, 16'h0102};
    want_o[1] = {3'b101, 16'h0001, 16'h0102};
    want_o[2] = {3'b010, 16'h0002, 16'h0506};
    rv = 1'b1; ra = 3'd1; av = 1'b1; ard = 3'd2; ad = 16'h0506;
    for (int i = 0; i < 3; i++) begin
      run_cycle(er, ar, eo, ao);
      checks += 2;
      if (ar !== er || ar !== want_r[i]) begin errors++; $display("FAIL rd_vs_wr_ready cyc=%0d act=%b req=%b", i, ar, want_r[i]); end
      if (ao !== eo || ao !== want_o[i]) begin errors++; $display("FAIL rd_vs_wr_out cyc=%0d act=%h req=%h", i, ao, want_o[i]); end
      if (er[2]) rv = 1'b0;
      if (er[1]) av = 1'b0;
    end
  endtask

  task automatic test_ab_round_robin();
    logic [2:0] er, ar; logic [OW-1:0] eo, ao;
    logic [2:0] want_r[5];
    want_r[0] = 3'b000; want_r[1] = 3'b010; want_r[2] = 3'b001; want_r[3] = 3'b010; want_r[4] = 3'b001;
    rst = 1'b1; av = 1'b1; ard = 3'd1; ad = 16'h0304; bv = 1'b1; brd = 3'd3; bd = 16'h0708;
    for (int i = 0; i < 6; i++) begin
      run_cycle(er, ar, eo, ao);
      rst = 1'b0;
      checks += 2;
      if (ar !== er || (i < 5 && ar !== want_r[i])) begin errors++; $display("FAIL ab_rr_ready cyc=%0d act=%b req=%b", i, ar, er); end
      if (ao !== eo) begin errors++; $display("FAIL ab_rr_out cyc=%0d act=%h req=%h", i, ao, eo); end
      if (er[1]) av = 1'b0;
      if (er[0]) bv = 1'b0;
      if (i == 2) begin av = 1'b1; bv = 1'b1; ad = 16'h1314; bd = 16'h1718; end
    end
    checks++;
    if (act_rf[3] !== 16'h1718 || act_rf[1] !== 16'h1314) begin
      errors++; $display("FAIL ab_rr_rf r1=%h r3=%h req=1314/1718", act_rf[1], act_rf[3]);
    end
  endtask

  task automatic test_starvation();
    logic [2:0] er, ar; logic [OW-1:0] eo, ao;
    rv = 1'b1; av = 1'b1; ard = 3'd6; ad = 16'h6060;
    for (int i = 0; i < 12; i++) begin
      ra = 3'($urandom_range(0, 7));
      run_cycle(er, ar, eo, ao);
      checks += 2;
      if (ar !== er || ar !== ((i % 5 == 4) ? 3'b010 : 3'b100)) begin errors++; $display("FAIL starve_ready cyc=%0d act=%b req=%b", i, ar, er); end
      if (ao !== eo) begin errors++; $display("FAIL starve_out cyc=%0d act=%h req=%h", i, ao, eo); end
    end
    idle_inputs();
  endtask

  task automatic test_all_three();
    logic [2:0] er, ar, want; logic [OW-1:0] eo, ao;
    run_cycle(er, ar, eo, ao);
    rv = 1'b1; av = 1'b1; bv = 1'b1;
    ard = 3'($urandom_range(1, 7)); ad = 16'($urandom);
    brd = 3'($urandom_range(1, 7)); bd = 16'($urandom);
    for (int i = 0; i < 20; i++) begin
      ra = 3'($urandom_range(0, 7));
      want = (i % 5 != 4) ? 3'b100 : (((i / 5) % 2 == 0) ? 3'b001 : 3'b010);
      run_cycle(er, ar, eo, ao);
      checks += 2;
      if (ar !== er || ar !== want) begin errors++; $display("FAIL all3_ready cyc=%0d act=%b req=%b", i, ar, want); end
      if (ao !== eo) begin errors++; $display("FAIL all3_out cyc=%0d act=%h req=%h", i, ao, eo); end
      if (er[1]) begin ard = 3'($urandom_range(1, 7)); ad = 16'($urandom); end
      if (er[0]) begin brd = 3'($urandom_range(1, 7)); bd = 16'($urandom); end
    end
    idle_inputs();
  endtask

  task automatic test_same_reg();
    logic [2:0] er, ar; logic [OW-1:0] eo, ao;
    rst = 1'b1; run_cycle(er, ar, eo, ao); rst = 1'b0;
    av = 1'b1; ard = 3'd4; ad = 16'hAAAA; bv = 1'b1; brd = 3'd4; bd = 16'hBBBB;
    for (int i = 0; i < 4; i++) begin
      run_cycle(er, ar, eo, ao);
      checks += 2;
      if (ar !== er) begin errors++; $display("FAIL same_reg_ready cyc=%0d act=%b req=%b", i, ar, er); end
      if (ao !== eo) begin errors++; $display("FAIL same_reg_out cyc=%0d act=%h req=%h", i, ao, eo); end
      if (er[1]) av = 1'b0;
      if (er[0]) bv = 1'b0;
    end
    checks++;
    if (act_rf[4] !== 16'hBBBB) begin errors++; $display("FAIL same_reg_rf r4=%h req=BBBB", act_rf[4]); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] er, ar; logic [OW-1:0] eo, ao;
    av = 1'b1; ard = 3'd5; ad = 16'h1111;
    run_cycle(er, ar, eo, ao); av = 1'b0;
    run_cycle(er, ar, eo, ao);
    av = 1'b1; ad = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      run_cycle(er, ar, eo, ao);
      checks += 2;
      if (ar !== er || (i == 0 && ar !== 3'b010)) begin errors++; $display("FAIL reset_mid_ready cyc=%0d act=%b req=%b", i, ar, er); end
      if (ao !== eo || (i == 1 && ao[33] !== 1'b0)) begin errors++; $display("FAIL reset_mid_out cyc=%0d act=%h req=%h", i, ao, eo); end
      av = 1'b0;
      rst = (i == 0);
    end
    checks++;
    if (act_rf[5] !== 16'h1111) begin errors++; $display("FAIL reset_mid_rf r5=%h req=1111", act_rf[5]); end
  endtask

  task automatic test_r0_write();
    logic [2:0] er, ar; logic [OW-1:0] eo, ao;
    logic req_wen;
`ifdef ARB_DROP_R0_EN
    req_wen = 1'b0;
`else
    req_wen = 1'b1;
`endif
    av = 1'b1; ard = 3'd0; ad = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      run_cycle(er, ar, eo, ao);
      checks += 2;
      if (ar !== er || (i == 0 && ar !== 3'b010)) begin errors++; $display("FAIL r0_ready cyc=%0d act=%b req=%b", i, ar, er); end
      if (ao !== eo || (i == 1 && (ao[33] !== req_wen || (req_wen && ao[31:16] !== 16'h0)))) begin
        errors++; $display("FAIL r0_out cyc=%0d act=%h req=%h", i, ao, eo);
      end
      av = 1'b0;
    end
    checks++;
    if (act_rf[0] !== 16'h0) begin errors++; $display("FAIL r0_value r0=%h req=0000", act_rf[0]); end
  endtask

  task automatic test_random();
    logic [2:0] er, ar; logic [OW-1:0] eo, ao;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!rv && $urandom_range(0, 1) == 1) begin rv = 1'b1; ra = 3'($urandom); end
      if (!av && $urandom_range(0, 2) == 0) begin av = 1'b1; ard = 3'($urandom); ad = 16'($urandom); end
      if (!bv && $urandom_range(0, 2) == 0) begin bv = 1'b1; brd = 3'($urandom); bd = 16'($urandom); end
      run_cycle(er, ar, eo, ao);
      checks += 2;
      if (ar !== er) begin errors++; $display("FAIL random_ready cyc=%0d act=%b req=%b", i, ar, er); end
      if (ao !== eo) begin errors++; $display("FAIL random_out cyc=%0d act=%h req=%h", i, ao, eo); end
      if (er[2]) rv = 1'b0;
      if (er[1]) av = 1'b0;
      if (er[0]) bv = 1'b0;
    end
    rst = 1'b0; idle_inputs();
    run_cycle(er, ar, eo, ao);
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (act_rf[r] !== exp_rf[r]) begin errors++; $display("FAIL random_rf r%0d act=%h req=%h", r, act_rf[r], exp_rf[r]); end
    end
  endtask

  initial begin
    rst = 1'b1; idle_inputs();
    ra = 3'd0; ard = 3'd0; brd = 3'd0; ad = 16'h0; bd = 16'h0;
    for (int r = 0; r < 8; r++) exp_rf[r] = 16'h0;
    model_reset();
    reset = 1'b1;
    bus.rd_valid = 1'b0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.rd_addr = 3'd0; bus.a_rd = 3'd0; bus.b_rd = 3'd0; bus.a_data = 16'h0; bus.b_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back({OW{1'b0}});
    test_reset();
    test_single_write();
    test_read_vs_write();
    test_ab_round_robin();
    test_starvation();
    test_all_three();
    test_same_reg();
    test_reset_mid();
    test_r0_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
